// File: rtl/rv_core_pkg.sv
// Shared constants and types for the RV32I core datapath blocks.
// Holds the control-flow opcodes, the pc-unit FSM encoding and the datapath width.
package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/rv_imm_extract.sv
// Splits an RV32I instruction into its opcode field and the sign-extended
// I-, B- and J-type immediates used by the next-pc logic.
module rv_imm_extract
  import rv_core_pkg::*;
(
  input  logic [XLEN-1:0] instruction,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] b_imm,
  output logic [XLEN-1:0] j_imm
);

  assign opcode = instruction[6:0];

  assign i_imm = {{20{instruction[31]}}, instruction[31:20]};

  // B and J immediates are scrambled in the encoding and always even.
  assign b_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};

  assign j_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: picks PC+4 / branch / JAL / JALR target, registers it,
// drives the fetch request, halts on misaligned targets and counts retirements.
module pc_next_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR     = 32'h0000_0000,
  parameter bit              HALT_ON_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            stall,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] instret
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            trap_q, trap_d;

  logic [6:0]      opcode;
  logic [XLEN-1:0] i_imm, b_imm, j_imm;
  logic [XLEN-1:0] jalr_sum, target;
  logic            is_jal, is_jalr, is_br_taken, nonseq, misaligned, advance;

  rv_imm_extract u_imm (
    .instruction (instruction),
    .opcode      (opcode),
    .i_imm       (i_imm),
    .b_imm       (b_imm),
    .j_imm       (j_imm)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_sum = rs1_val + i_imm;

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path leaves a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    trap_d      = trap_q;
    trap_pc_d   = trap_pc_q;
    imem_req    = 1'b0;
    redirect    = 1'b0;

    is_jalr     = (opcode == OP_JALR);
    is_jal      = (opcode == OP_JAL);
    is_br_taken = (opcode == OP_BRANCH) && branch_taken;
    nonseq      = is_jalr || is_jal || is_br_taken;

    if (is_jalr)     target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (is_jal) target = pc_q + j_imm;
    else             target = pc_q + b_imm;

    misaligned  = nonseq && (target[1:0] != 2'b00);
    advance     = (state_q == RUN) && imem_ready && !stall;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imem_req = 1'b1;
        if (advance) begin
          if (misaligned && HALT_ON_MISALIGN) begin
            trap_d    = 1'b1;
            trap_pc_d = pc_q;
            state_d   = HALT;
          end else begin
            // Clearing bits [1:0] is a no-op for aligned targets.
            pc_d      = nonseq ? {target[XLEN-1:2], 2'b00} : pc_plus4;
            redirect  = nonseq;
            instret_d = instret_q + 32'd1;
          end
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      instret_q <= '0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign pc      = pc_q;
  assign instret = instret_q;
  assign trap    = trap_q;
  assign trap_pc = trap_pc_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit: two instances (halting and force-aligning)
// share stimulus; expected per-cycle outputs are queued and checked by a negedge monitor.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0000_0013;
  logic        branch_taken = 1'b0;
  logic [31:0] rs1_val = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;

  logic        imem_req0, redirect0, trap0;
  logic [31:0] pc0, pc_plus4_0, trap_pc0, instret0;
  logic        imem_req1, redirect1, trap1;
  logic [31:0] pc1, pc_plus4_1, trap_pc1, instret1;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JALR0    = 32'h0000_0067;  // jalr x0, 0(x0)
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;  // beq x0, x0, -8
  localparam logic [31:0] JAL_P2   = 32'h0020_006F;  // jal x0, +2

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_VECTOR(32'h0000_0100), .HALT_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .instruction(instruction), .branch_taken(branch_taken),
    .rs1_val(rs1_val), .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req0),
    .pc(pc0), .pc_plus4(pc_plus4_0), .redirect(redirect0), .trap(trap0),
    .trap_pc(trap_pc0), .instret(instret0)
  );

  pc_next_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .HALT_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .instruction(instruction), .branch_taken(branch_taken),
    .rs1_val(rs1_val), .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req1),
    .pc(pc1), .pc_plus4(pc_plus4_1), .redirect(redirect1), .trap(trap1),
    .trap_pc(trap_pc1), .instret(instret1)
  );

  typedef struct {
    int          tag;
    bit          dut;
    logic [31:0] pc;
    logic        req;
    logic        redir;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cur_tag = 0;
  bit   done = 1'b0;

  // Drive one cycle of inputs just after the rising edge.
  task automatic step(input logic r, input logic [31:0] ins, input logic bt,
                      input logic [31:0] rs1, input logic st, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; instruction = ins; branch_taken = bt; rs1_val = rs1;
    stall = st; imem_ready = rdy;
    cur_tag++;
  endtask

  task automatic expect_out(input bit d, input logic [31:0] p, input logic req,
                            input logic redir, input logic tr, input logic [31:0] tpc,
                            input logic [31:0] ir);
    exp_t e;
    e.tag = cur_tag; e.dut = d; e.pc = p; e.req = req; e.redir = redir;
    e.trap = tr; e.trap_pc = tpc; e.instret = ir; e.pc_plus4 = p + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [31:0] a_pc, a_tpc, a_ir, a_p4;
    logic        a_req, a_redir, a_trap;
    if (e.dut == 1'b0) begin
      a_pc = pc0; a_req = imem_req0; a_redir = redirect0; a_trap = trap0;
      a_tpc = trap_pc0; a_ir = instret0; a_p4 = pc_plus4_0;
    end else begin
      a_pc = pc1; a_req = imem_req1; a_redir = redirect1; a_trap = trap1;
      a_tpc = trap_pc1; a_ir = instret1; a_p4 = pc_plus4_1;
    end
    n_cmp++;
    if (a_pc !== e.pc || a_req !== e.req || a_redir !== e.redir || a_trap !== e.trap ||
        a_tpc !== e.trap_pc || a_ir !== e.instret || a_p4 !== e.pc_plus4) begin
      n_fail++;
      $display("FAIL step%0d dut%0d: got pc=%h req=%b redir=%b trap=%b trap_pc=%h instret=%0d pc4=%h | want pc=%h req=%b redir=%b trap=%b trap_pc=%h instret=%0d pc4=%h",
               e.tag, e.dut, a_pc, a_req, a_redir, a_trap, a_tpc, a_ir, a_p4,
               e.pc, e.req, e.redir, e.trap, e.trap_pc, e.instret, e.pc_plus4);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    while (!done) begin
      @(negedge clk);
      while (exp_q.size() > 0) check(exp_q.pop_front());
    end
  end

  initial begin
    // Reset for two edges, then BOOT, then sequential NOP fetch.
    step(1, NOP, 0, 0, 0, 1);            expect_out(0, 32'h100, 0, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h100, 0, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h100, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h104, 1, 0, 0, 0, 1);
    // JALR to 0x200 (bit0 of 0x201 cleared).
    step(0, JALR0, 0, 32'h201, 0, 1);    expect_out(0, 32'h108, 1, 1, 0, 0, 2);
    // Taken BEQ -8 at 0x200.
    step(0, BEQ_M8, 1, 0, 0, 1);         expect_out(0, 32'h200, 1, 1, 0, 0, 3);
    // JALR rs1=0x1001 -> 0x1000.
    step(0, JALR0, 0, 32'h1001, 0, 1);   expect_out(0, 32'h1F8, 1, 1, 0, 0, 4);
    step(0, JALR0, 0, 32'h200, 0, 1);    expect_out(0, 32'h1000, 1, 1, 0, 0, 5);
    // Untaken BEQ at 0x200.
    step(0, BEQ_M8, 0, 0, 0, 1);         expect_out(0, 32'h200, 1, 0, 0, 0, 6);
    step(0, JALR0, 0, 32'h300, 0, 1);    expect_out(0, 32'h204, 1, 1, 0, 0, 7);
    // Memory wait x3 then stall x1 with a misaligned JAL present: no advance, no trap.
    for (int i = 0; i < 3; i++) begin
      step(0, JAL_P2, 0, 0, 0, 0);       expect_out(0, 32'h300, 1, 0, 0, 0, 8);
    end
    step(0, JAL_P2, 0, 0, 1, 1);         expect_out(0, 32'h300, 1, 0, 0, 0, 8);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h300, 1, 0, 0, 0, 8);
    step(0, JALR0, 0, 32'h400, 0, 1);    expect_out(0, 32'h304, 1, 1, 0, 0, 9);
    // Misaligned JAL at 0x400 -> HALT.
    step(0, JAL_P2, 0, 0, 0, 1);         expect_out(0, 32'h400, 1, 0, 0, 0, 10);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h400, 0, 0, 1, 32'h400, 10);
    step(0, JALR0, 0, 32'h800, 0, 1);    expect_out(0, 32'h400, 0, 0, 1, 32'h400, 10);
    step(1, NOP, 0, 0, 0, 1);            expect_out(0, 32'h400, 0, 0, 1, 32'h400, 10);
    // Out of reset again; dut1 now checked for wrap and force-align.
    step(0, NOP, 0, 0, 0, 1);
    expect_out(0, 32'h100, 0, 0, 0, 0, 0);
    expect_out(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 1);
    expect_out(0, 32'h100, 1, 0, 0, 0, 0);
    expect_out(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    step(0, JAL_P2, 0, 0, 0, 1);
    expect_out(0, 32'h104, 1, 0, 0, 0, 1);
    expect_out(1, 32'h0, 1, 1, 0, 0, 1);
    step(0, NOP, 0, 0, 0, 1);
    expect_out(0, 32'h104, 0, 0, 1, 32'h104, 1);
    expect_out(1, 32'h0, 1, 0, 0, 0, 2);
    // rst coinciding with a misaligned advance: reset wins, no trap.
    step(1, NOP, 0, 0, 0, 1);            expect_out(0, 32'h104, 0, 0, 1, 32'h104, 1);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h100, 0, 0, 0, 0, 0);
    step(1, JAL_P2, 0, 0, 0, 1);         expect_out(0, 32'h100, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 1);            expect_out(0, 32'h100, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
